// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared RAM/arbiter types and default sizing
package ram_arbiter_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
   typedef enum logic [1:0] {IDLE_A, HOLD_A, FLUSH_A} arb_state_t;
   localparam int ARB_NREQ_DEF    = 4;
   localparam int ARB_BURST_DEF   = 2;
   localparam int ARB_TIMEOUT_DEF = 64;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: cache-side request bus plus the single RAM port
interface ram_arbiter_if #(
   parameter int NREQ = ram_arbiter_pkg::ARB_NREQ_DEF,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
);
   import ram_arbiter_pkg::*;
   logic [NREQ-1:0] req_ren, req_wen, req_wait, req_err;
   word_t [NREQ-1:0] req_addr, req_store, req_load;
   logic ramREN, ramWEN;
   word_t ramaddr, ramstore, ramload;
   ramstate_t ramstate;
   logic grant_vld;
   logic [IDW-1:0] grant_id;
   modport master (
      output req_ren, req_wen, req_addr, req_store, ramload, ramstate,
      input req_wait, req_load, req_err, ramREN, ramWEN, ramaddr, ramstore, grant_vld, grant_id
   );
   modport slave (
      input req_ren, req_wen, req_addr, req_store, ramload, ramstate,
      output req_wait, req_load, req_err, ramREN, ramWEN, ramaddr, ramstore, grant_vld, grant_id
   );
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: rotate-priority encoder, first active requester after last_id
module rr_pick #(
   parameter int NREQ = 4,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_id,
   output logic            hit,
   output logic [IDW-1:0]  id
);
   logic [IDW-1:0] idx;
   // walk the ring backwards so the requester nearest to last_id+1 is written last
   always_comb begin
      hit = |req;
      id  = '0;
      idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IDW'((int'(last_id) + k) % NREQ);
         if (req[idx]) id = idx;
      end
   end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin, burst-locked RAM sharing with per-beat watchdog
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int NREQ    = ARB_NREQ_DEF,
   parameter int BURST   = ARB_BURST_DEF,
   parameter int TIMEOUT = ARB_TIMEOUT_DEF,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int BW  = $clog2(BURST) + 1,
   localparam int WW  = $clog2(TIMEOUT) + 1
) (
   input logic CLK,
   input logic nRST,
   ram_arbiter_if.slave bus
);
   arb_state_t state, state_n;
   logic [IDW-1:0] grant_id, grant_n, last_id, last_n, pick;
   logic [BW-1:0] beat, beat_n;
   logic [WW-1:0] wdog, wdog_n;
   logic [NREQ-1:0] active;
   logic hit, drive;

   assign active = bus.req_ren | bus.req_wen;

   rr_pick #(.NREQ(NREQ)) u_pick (.req(active), .last_id(last_id), .hit(hit), .id(pick));

   // arbiter state; reset drops any burst in flight immediately
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= IDLE_A;
         grant_id <= '0;
         last_id  <= IDW'(NREQ - 1);
         beat     <= '0;
         wdog     <= '0;
      end else begin
         state    <= state_n;
         grant_id <= grant_n;
         last_id  <= last_n;
         beat     <= beat_n;
         wdog     <= wdog_n;
      end
   end

   // next state plus RAM drive and per-beat handshake back to the grantee
   always_comb begin
      state_n       = state;
      grant_n       = grant_id;
      last_n        = last_id;
      beat_n        = beat;
      wdog_n        = wdog;
      drive         = (state == HOLD_A) && active[grant_id];
      bus.ramREN    = drive && !bus.req_wen[grant_id];
      bus.ramWEN    = drive && bus.req_wen[grant_id];
      bus.ramaddr   = drive ? bus.req_addr[grant_id] : '0;
      bus.ramstore  = (drive && bus.req_wen[grant_id]) ? bus.req_store[grant_id] : '0;
      bus.req_wait  = '1;
      bus.req_load  = '0;
      bus.req_err   = '0;
      bus.grant_vld = state == HOLD_A;
      bus.grant_id  = grant_id;
      if (state == IDLE_A) begin
         if (hit) begin
            state_n = HOLD_A;
            grant_n = pick;
            beat_n  = '0;
            wdog_n  = '0;
         end
      end else if (state == FLUSH_A) begin
         state_n = IDLE_A;
      end else if (!drive) begin
         last_n  = grant_id;
         state_n = IDLE_A;
      end else if (bus.ramstate == ACCESS) begin
         bus.req_wait[grant_id] = 1'b0;
         bus.req_load[grant_id] = bus.ramload;
         beat_n = beat + 1'b1;
         wdog_n = '0;
         if (beat == BW'(BURST - 1)) begin
            last_n  = grant_id;
            state_n = IDLE_A;
         end
      end else if (bus.ramstate == ERROR || wdog == WW'(TIMEOUT - 1)) begin
         bus.req_err[grant_id] = 1'b1;
         last_n  = grant_id;
         state_n = FLUSH_A;
      end else begin
         wdog_n = wdog + 1'b1;
      end
   end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter that shares the single-ported RAM between NREQ cache-side requesters (I-cache and D-cache ports of both cores). It sits between the caches and the RAM and replaces fixed-priority selection with fair, burst-locked grants, so a two-word block fill or writeback is never split. A per-grant watchdog also frees the bus if the RAM stalls.

## Interface
- NREQ, 4, number of requesters; index 0..NREQ-1, with IDW = $clog2(NREQ).
- BURST, 2, words per grant (beats); 1..4.
- TIMEOUT, 64, maximum cycles a beat may wait for ACCESS before abort; >= 2.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- req_ren  in  NREQ  read request per requester.
- req_wen  in  NREQ  write request per requester.
- req_addr  in  NREQ x 32  word address per requester, updated by the requester per beat.
- req_store  in  NREQ x 32  write data per requester.
- req_wait  out  NREQ  1 = stall. Low for exactly one cycle per completed beat, and only for the granted requester.
- req_load  out  NREQ x 32  ramload routed to the granted requester; 0 elsewhere.
- req_err  out  NREQ  one-cycle pulse to the granted requester on RAM ERROR or timeout.
- ramREN / ramWEN  out  1 each  RAM strobes.
- ramaddr / ramstore  out  32 each  RAM address and data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR.
- grant_vld  out  1  a grant is held.
- grant_id  out  IDW  current or most recent grantee.

## Operation
- FSM states: IDLE, HOLD, FLUSH. Registers: state, grant_id, last_id, beat (width $clog2(BURST)+1), wdog (width $clog2(TIMEOUT)+1).
- Reset values:
  - state=IDLE, grant_id=0, last_id=NREQ-1, beat=0, wdog=0.
  - All outputs 0, except req_wait = all ones.
- IDLE arbitration:
  - A requester is active when req_ren|req_wen is set.
  - Round-robin search starts at last_id+1 mod NREQ. The first active requester is latched as grant_id.
  - On a win: beat=0, wdog=0, next state HOLD.
  - If no requester is active, stay in IDLE.
- HOLD RAM drive (combinational from registered grant_id):
  - ramaddr = req_addr[g].
  - If req_wen[g]: ramWEN=1, ramstore=req_store[g], ramREN=0. Write takes precedence when ren and wen are both set.
  - Otherwise ramREN=1.
- HOLD, ramstate==ACCESS:
  - req_wait[g]=0 that cycle; req_load[g]=ramload.
  - beat increments and wdog clears.
  - If beat==BURST-1: last_id=g, next state IDLE.
- HOLD, ramstate==ERROR or wdog==TIMEOUT-1:
  - req_err[g] pulses and req_wait[g] stays 1.
  - last_id=g, next state FLUSH.
- HOLD, otherwise: wdog increments.
- HOLD, requester drops both ren and wen before the final beat (early release):
  - RAM strobes drop the same cycle.
  - last_id=g, next state IDLE. No error.
- FLUSH: drives no strobes for one cycle, then goes to IDLE. This lets the RAM return to FREE before the next grant.
- No requester other than g ever sees req_wait=0 or nonzero req_load.
- grant_vld=1 only in HOLD.

## Timing
- Request to RAM strobe latency: 1 cycle. The request is sampled in IDLE on edge N, and strobes are driven from cycle N+1.
- The beat handshake is combinational on ramstate. req_wait drop is coincident with ACCESS, and data is valid in that same cycle.
- Back-to-back grants: after the final ACCESS, 1 idle arbitration cycle before the next grant's strobes.
- Minimum occupancy per grant is BURST+1 cycles with zero-wait RAM.
- Fairness: a continuously requesting port waits at most (NREQ-1) grants.
- Simultaneous new requests in IDLE resolve by the round-robin order only; read vs write does not affect priority.
- Asynchronous reset mid-burst returns to the reset values immediately. The RAM strobes drop without completing the burst.

## Structure
- Shared package diaosi_types_pkg gains:
  - arb_state_t (IDLE_A, HOLD_A, FLUSH_A).
  - Constants ARB_NREQ_DEF=4, ARB_BURST_DEF=2, ARB_TIMEOUT_DEF=64.
- ramstate_t and word_t are reused from cpu_types_pkg.
- One sub-module, rr_pick: a combinational rotate-priority encoder with inputs req vector and last_id, and outputs hit and id. It is also reused by the future coherence bus.

## Test plan
- Single read, zero-wait RAM: req_ren[2]=1 at addr 0x40, then 0x44. Expect ramREN at cycle+1, req_wait[2] low for 2 cycles, 2 ACCESS beats, return to IDLE, last_id=2.
- All four requesters held active for 8 grants: expect grant order 0,1,2,3,0,1,2,3.
- ren+wen both set on requester 1 with store 0xDEADBEEF: expect ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
- RAM held BUSY with TIMEOUT=8: expect req_err pulse at the 8th HOLD cycle, one FLUSH cycle, then the next requester granted.
- Requester 3 drops ren after beat 0 of 2: expect strobes low the same cycle, FSM in IDLE on the next edge, no req_err.
- nRST asserted mid-burst on beat 1: expect req_wait all ones, strobes 0, grant_vld=0 immediately. After release, requester 0 wins the first arbitration.
